instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
- Registered RV32I decode stage that consumes 32-bit instruction words from the instruction ROM/fetch path and produces decoded fields, a sign-extended immediate and control flags.
- Performs the inverse of the test-program instruction generator: it recognises the R, I-imm, LOAD, STORE, BRANCH and JAL formats.
- Sits between fetch and execute.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so that in_ready is a registered signal.

Parameters:
- PC_W, 32, width of program counter carried with each instruction
- ILLEGAL_AS_NOP, 1, when 1 an illegal instruction has all write/mem/branch/jump flags forced to 0 (still flagged)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word and PC present
- in_ready  out  1  stage can accept a word this cycle (registered)
- in_instr  in  32  raw instruction
- in_pc  in  PC_W  PC of in_instr
- flush  in  1  discard all held and in-flight entries
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts the bundle
- out_pc  out  PC_W  PC of the decoded instruction
- out_class  out  3  0=R, 1=IMM, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL, 7=ILLEGAL
- out_rd, out_rs1, out_rs2  out  5 each  register fields (0 when unused by the format)
- out_funct3  out  3  funct3 (0 for JAL)
- out_funct7  out  7  funct7 (0 unless R-type)
- out_imm  out  32  sign-extended immediate
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_alu_imm  out  1 each  control flags
- out_illegal  out  1  unsupported opcode, or illegal funct3/funct7 combination

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, in_ready=1, both skid entries empty.
  - All bundle outputs = 0.
  - A reset mid-transfer drops all held entries.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency:
  - 1 cycle when empty: a word accepted at edge N gives out_valid=1 with its decoded bundle after edge N.
  - Decode is combinational on the input; results are registered.
- Storage and ordering:
  - Two entries: the output register plus one skid entry.
  - in_ready = !skid_full, registered.
  - A word accepted while the output is valid and not draining goes to the skid entry.
  - When the output drains, the skid entry moves to the output register.
  - Strict FIFO order.
- Occupancy states: EMPTY (out_valid=0), ONE (out valid, skid empty), FULL (both valid, in_ready=0).
  - EMPTY: accept -> ONE.
  - ONE:
    - accept without drain -> FULL.
    - accept with drain -> ONE (new word goes to the output).
    - drain only -> EMPTY.
  - FULL: drain -> ONE. No accept is possible because in_ready=0.
- Output stability: while out_valid && !out_ready, every out_* signal holds stable.
- flush:
  - Synchronous. Next edge: state EMPTY, out_valid=0, in_ready=1.
  - Flush has priority over a simultaneous input transfer; the input word is dropped.
  - A simultaneous output transfer still completes.
- Immediates, per standard RV32I:
  - I/LOAD: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R: imm = 0.
- Legality:
  - R-type: funct7 must be 0, or 32 only when funct3 is 0 (ADD/SUB) or 5 (SRL/SRA).
  - I-imm: for funct3=1, funct7 must be 0. For funct3=5, funct7 must be 0 or 32.
  - LOAD: funct3 must be 2 (LW only).
  - STORE: funct3 must be 2 (SW only).
  - BRANCH: funct3 of 2 or 3 is illegal.
  - Any other opcode -> class 7, illegal=1.
- Flags:
  - reg_write: R, IMM, LOAD, JAL (0 if rd==0).
  - mem_read: LOAD.
  - mem_write: STORE.
  - branch: BRANCH.
  - jump: JAL.
  - alu_imm: IMM, LOAD, STORE.
- Illegal instructions with ILLEGAL_AS_NOP=1: all flags 0; fields still reported.

Decomposition:
- Opcodes, funct3 codes and class encodings are shared constants in constant_def.vh; class values are added there.
- The combinational immediate extractor is a natural sub-module, imm_gen (instr in, class in, imm out).

Test Plan:
- 0x002081B3 (add x3,x1,x2) after reset -> 1 cycle later: class 0, rd=3, rs1=1, rs2=2, imm=0, reg_write=1, illegal=0.
- 0xFFF00293 (addi x5,x0,-1) -> class 1, imm=0xFFFFFFFF, alu_imm=1.
- 0x0020A423 (sw x2,8(x1)) -> class 3, imm=8, mem_write=1, reg_write=0.
- 0xFE208EE3 (beq x1,x2,-4) -> class 4, imm=0xFFFFFFFC, branch=1.
- 0x001000EF (jal x1,2048) -> class 5, imm=0x800, jump=1.
- 0x00000000 -> illegal=1, class 7, all flags 0.
- Back-pressure: hold out_ready=0 and send 3 words.
  - in_ready falls after the 2nd accept; the 3rd word waits.
  - Release out_ready -> bundles drain in order with stable contents.
- flush while FULL -> next cycle out_valid=0, in_ready=1; a word presented on the flush cycle never appears.
- Assert rst_n low mid-stall -> out_valid drops immediately (asynchronously), in_ready=1.

Source files
------------

// File: rtl/instr_decode_stage_pkg.sv
// Shared RV32I decode constants: opcodes, funct codes, instruction classes,
// the registered bundle layout and the skid-buffer occupancy states.
package instr_decode_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_WORD    = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_IMM     = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_ILLEGAL = 3'd7
    } instr_class_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    typedef struct packed {
        instr_class_t cls;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [2:0]   funct3;
        logic [6:0]   funct7;
        logic [31:0]  imm;
        logic         reg_write;
        logic         mem_read;
        logic         mem_write;
        logic         branch;
        logic         jump;
        logic         alu_imm;
        logic         illegal;
    } bundle_t;

endpackage

// File: rtl/instr_decode_stage_imm_gen.sv
// Combinational RV32I immediate extractor. Bits [6:0] (opcode) play no part
// in any immediate, so only instr[31:7] is brought in.
module instr_decode_stage_imm_gen
    import instr_decode_stage_pkg::*;
(
    input  logic [31:7]  instr,
    input  instr_class_t cls,
    output logic [31:0]  imm
);

    // Select and sign-extend the immediate layout of the decoded format.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        imm = '0;
        case (cls)
            CLS_IMM, CLS_LOAD: imm = {{20{instr[31]}}, instr[31:20]};
            CLS_STORE:         imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            CLS_BRANCH:        imm = {{19{instr[31]}}, instr[31], instr[7],
                                      instr[30:25], instr[11:8], 1'b0};
            CLS_JAL:           imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                      instr[20], instr[30:21], 1'b0};
            default:           imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32I decode stage between fetch and execute. Decode is purely
// combinational on the incoming word; the result lands in an output register
// backed by one skid entry so that in_ready comes straight from a flop.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int PC_W           = 32,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [2:0]      out_class,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [31:0]     out_imm,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_alu_imm,
    output logic            out_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    instr_class_t    dec_cls;
    logic [31:0]     dec_imm;
    bundle_t         dec;
    bundle_t         out_q;
    bundle_t         skid_q;
    logic [PC_W-1:0] out_pc_q;
    logic [PC_W-1:0] skid_pc_q;
    occ_t            state;
    logic            accept;
    logic            drain;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // Map the opcode to its instruction format class.
    always_comb begin
        dec_cls = CLS_ILLEGAL;
        case (opcode)
            OPC_OP:     dec_cls = CLS_R;
            OPC_OP_IMM: dec_cls = CLS_IMM;
            OPC_LOAD:   dec_cls = CLS_LOAD;
            OPC_STORE:  dec_cls = CLS_STORE;
            OPC_BRANCH: dec_cls = CLS_BRANCH;
            OPC_JAL:    dec_cls = CLS_JAL;
            default:    dec_cls = CLS_ILLEGAL;
        endcase
    end

    instr_decode_stage_imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .cls   (dec_cls),
        .imm   (dec_imm)
    );

    // Extract fields used by the format, check legality and derive control flags.
    // Unknown opcodes report no fields at all since no format applies.
    always_comb begin
        dec     = '0;
        dec.cls = dec_cls;
        dec.imm = dec_imm;
        case (dec_cls)
            CLS_R: begin
                dec = '{cls: CLS_R, rd: in_instr[11:7], rs1: in_instr[19:15],
                        rs2: in_instr[24:20], funct3: funct3, funct7: funct7,
                        imm: '0, reg_write: 1'b1, default: 1'b0};
                dec.illegal = !((funct7 == F7_BASE) ||
                                ((funct7 == F7_ALT) &&
                                 ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA))));
            end
            CLS_IMM: begin
                dec.rd        = in_instr[11:7];
                dec.rs1       = in_instr[19:15];
                dec.funct3    = funct3;
                dec.reg_write = 1'b1;
                dec.alu_imm   = 1'b1;
                dec.illegal   = ((funct3 == F3_SLL) && (funct7 != F7_BASE)) ||
                                ((funct3 == F3_SRL_SRA) && (funct7 != F7_BASE) &&
                                 (funct7 != F7_ALT));
            end
            CLS_LOAD: begin
                dec.rd        = in_instr[11:7];
                dec.rs1       = in_instr[19:15];
                dec.funct3    = funct3;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.alu_imm   = 1'b1;
                dec.illegal   = (funct3 != F3_WORD);
            end
            CLS_STORE: begin
                dec.rs1       = in_instr[19:15];
                dec.rs2       = in_instr[24:20];
                dec.funct3    = funct3;
                dec.mem_write = 1'b1;
                dec.alu_imm   = 1'b1;
                dec.illegal   = (funct3 != F3_WORD);
            end
            CLS_BRANCH: begin
                dec.rs1     = in_instr[19:15];
                dec.rs2     = in_instr[24:20];
                dec.funct3  = funct3;
                dec.branch  = 1'b1;
                dec.illegal = (funct3 == F3_WORD) || (funct3 == F3_SLTU);
            end
            CLS_JAL: begin
                dec.rd        = in_instr[11:7];
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
        if (ILLEGAL_AS_NOP && dec.illegal) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
            dec.alu_imm   = 1'b0;
        end
    end

    // Occupancy FSM: moves words through output register and skid entry in FIFO order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OCC_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            // NOTE: the data registers are reset too, because every bundle output must read 0 out of reset.
            out_q     <= '0;
            out_pc_q  <= '0;
            skid_q    <= '0;
            skid_pc_q <= '0;
        end else if (flush) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state     <= OCC_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        out_q     <= dec;
                        out_pc_q  <= in_pc;
                        out_valid <= 1'b1;
                        state     <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && !drain) begin
                        skid_q    <= dec;
                        skid_pc_q <= in_pc;
                        in_ready  <= 1'b0;
                        state     <= OCC_FULL;
                    end else if (accept) begin
                        out_q    <= dec;
                        out_pc_q <= in_pc;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (drain) begin
                        out_q    <= skid_q;
                        out_pc_q <= skid_pc_q;
                        in_ready <= 1'b1;
                        state    <= OCC_ONE;
                    end
                end
                default: begin
                    state     <= OCC_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_pc        = out_pc_q;
    assign out_class     = out_q.cls;
    assign out_rd        = out_q.rd;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_funct3    = out_q.funct3;
    assign out_funct7    = out_q.funct7;
    assign out_imm       = out_q.imm;
    assign out_reg_write = out_q.reg_write;
    assign out_mem_read  = out_q.mem_read;
    assign out_mem_write = out_q.mem_write;
    assign out_branch    = out_q.branch;
    assign out_jump      = out_q.jump;
    assign out_alu_imm   = out_q.alu_imm;
    assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed RV32I words, back-pressure,
// flush and asynchronous reset, then randomized traffic against a queue-based
// reference model of a 2-deep FIFO with an arithmetic RV32I decoder.
module tb_instr_decode_stage;

    localparam int PC_W = 32;

    typedef logic [98:0] vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [2:0]      out_class;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [31:0]     out_imm;
    logic            out_reg_write;
    logic            out_mem_read;
    logic            out_mem_write;
    logic            out_branch;
    logic            out_jump;
    logic            out_alu_imm;
    logic            out_illegal;

    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        model_q[$];
    logic [31:0] pc_ctr = 32'h0000_1000;

    instr_decode_stage #(.PC_W(PC_W), .ILLEGAL_AS_NOP(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_class     (out_class),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_funct3    (out_funct3),
        .out_funct7    (out_funct7),
        .out_imm       (out_imm),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_branch    (out_branch),
        .out_jump      (out_jump),
        .out_alu_imm   (out_alu_imm),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic vec_t observed();
        return {out_pc, out_class, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm,
                out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump,
                out_alu_imm, out_illegal};
    endfunction

    // Reference decoder: immediates rebuilt by signed integer arithmetic.
    function automatic vec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        int         s;
        int         imm;
        int         f3i;
        int         f7i;
        logic [2:0] cls;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       wr, mr, mw, br, jp, ai, ill;
        s   = $signed(ins);
        f3i = int'(ins[14:12]);
        f7i = int'(ins[31:25]);
        imm = 0;
        rd = '0; rs1 = '0; rs2 = '0; f3 = '0; f7 = '0;
        wr = 0; mr = 0; mw = 0; br = 0; jp = 0; ai = 0; ill = 0;
        case (ins[6:0])
            7'h33: begin
                cls = 3'd0; rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
                f3 = ins[14:12]; f7 = ins[31:25]; wr = 1;
                ill = !(f7i == 0 || (f7i == 32 && (f3i == 0 || f3i == 5)));
            end
            7'h13: begin
                cls = 3'd1; rd = ins[11:7]; rs1 = ins[19:15]; f3 = ins[14:12];
                imm = s >>> 20; wr = 1; ai = 1;
                ill = (f3i == 1 && f7i != 0) || (f3i == 5 && f7i != 0 && f7i != 32);
            end
            7'h03: begin
                cls = 3'd2; rd = ins[11:7]; rs1 = ins[19:15]; f3 = ins[14:12];
                imm = s >>> 20; wr = 1; mr = 1; ai = 1; ill = (f3i != 2);
            end
            7'h23: begin
                cls = 3'd3; rs1 = ins[19:15]; rs2 = ins[24:20]; f3 = ins[14:12];
                imm = (s >>> 25) * 32 + int'(ins[11:7]); mw = 1; ai = 1; ill = (f3i != 2);
            end
            7'h63: begin
                cls = 3'd4; rs1 = ins[19:15]; rs2 = ins[24:20]; f3 = ins[14:12];
                imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                      + int'(ins[11:8]) * 2;
                br = 1; ill = (f3i == 2 || f3i == 3);
            end
            7'h6f: begin
                cls = 3'd5; rd = ins[11:7];
                imm = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                      + int'(ins[30:21]) * 2;
                wr = 1; jp = 1;
            end
            default: begin
                cls = 3'd7; ill = 1;
            end
        endcase
        if (rd == 5'd0) wr = 0;
        if (ill) begin
            wr = 0; mr = 0; mw = 0; br = 0; jp = 0; ai = 0;
        end
        return {pc, cls, rd, rs1, rs2, f3, f7, 32'(imm), wr, mr, mw, br, jp, ai, ill};
    endfunction

    // One clock cycle: drive inputs at the falling edge, check DUT against the model,
    // then advance the model by what the coming rising edge will do.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        int occ;
        @(negedge clk);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc_ctr;
        out_ready = rdy;
        flush     = fl;
        occ = model_q.size();
        check("out_valid", 128'(out_valid), 128'(occ > 0));
        check("in_ready", 128'(in_ready), 128'(occ < 2));
        if (occ > 0) begin
            check("bundle", 128'(observed()), 128'(model_q[0]));
            if (rdy) void'(model_q.pop_front());
        end
        if (fl) model_q.delete();
        else if (v && occ < 2) model_q.push_back(ref_decode(ins, pc_ctr));
        pc_ctr = pc_ctr + 32'd4;
    endtask

    task automatic directed(input string tag, input logic [31:0] ins, input logic [2:0] cls,
                            input logic [31:0] imm, input logic [6:0] flags);
        cycle(1'b1, ins, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check({tag, "_class"}, 128'(out_class), 128'(cls));
        check({tag, "_imm"}, 128'(out_imm), 128'(imm));
        check({tag, "_flags"}, 128'({out_reg_write, out_mem_read, out_mem_write, out_branch,
                                     out_jump, out_alu_imm, out_illegal}), 128'(flags));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int          k;
        ins = $urandom;
        k   = $urandom_range(0, 6);
        case (k)
            0: ins[6:0] = 7'h33;
            1: ins[6:0] = 7'h13;
            2: ins[6:0] = 7'h03;
            3: ins[6:0] = 7'h23;
            4: ins[6:0] = 7'h63;
            5: ins[6:0] = 7'h6f;
            default: ;
        endcase
        if (k <= 1) begin
            case ($urandom_range(0, 2))
                0: ins[31:25] = 7'd0;
                1: ins[31:25] = 7'd32;
                default: ;
            endcase
        end
        if ((k == 2 || k == 3) && $urandom_range(0, 1) == 1) ins[14:12] = 3'd2;
        return ins;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_bundle", 128'(observed()), 128'(0));
        rst_n = 1'b1;

        directed("add", 32'h002081B3, 3'd0, 32'h0, 7'b1000000);
        check("add_regs", 128'({out_rd, out_rs1, out_rs2}), 128'({5'd3, 5'd1, 5'd2}));
        directed("addi", 32'hFFF00293, 3'd1, 32'hFFFFFFFF, 7'b1000010);
        directed("sw", 32'h0020A423, 3'd3, 32'h8, 7'b0010010);
        directed("beq", 32'hFE208EE3, 3'd4, 32'hFFFFFFFC, 7'b0001000);
        directed("jal", 32'h001000EF, 3'd5, 32'h800, 7'b1000100);
        directed("zero", 32'h00000000, 3'd7, 32'h0, 7'b0000001);
        directed("lb", 32'h00000083, 3'd2, 32'h0, 7'b0000001);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: third word must wait while two are held.
        cycle(1'b1, 32'h00308133, 1'b0, 1'b0);
        cycle(1'b1, 32'h00A00513, 1'b0, 1'b0);
        cycle(1'b1, 32'h0040A623, 1'b0, 1'b0);
        check("bp_in_ready_low", 128'(in_ready), 128'(0));
        cycle(1'b1, 32'h0040A623, 1'b0, 1'b0);
        cycle(1'b1, 32'h0040A623, 1'b1, 1'b0);
        cycle(1'b1, 32'h0040A623, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while FULL, and flush beating a simultaneous accept in ONE.
        cycle(1'b1, 32'h00110113, 1'b0, 1'b0);
        cycle(1'b1, 32'h00210113, 1'b0, 1'b0);
        cycle(1'b1, 32'h00310113, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("flush_full_valid", 128'(out_valid), 128'(0));
        check("flush_full_ready", 128'(in_ready), 128'(1));
        cycle(1'b1, 32'h00410113, 1'b0, 1'b0);
        cycle(1'b1, 32'h00510113, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("flush_one_valid", 128'(out_valid), 128'(0));

        // Asynchronous reset in the middle of a stall.
        cycle(1'b1, 32'h00610113, 1'b0, 1'b0);
        cycle(1'b1, 32'h00710113, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'(0));
        check("async_rst_ready", 128'(in_ready), 128'(1));
        check("async_rst_bundle", 128'(observed()), 128'(0));
        model_q.delete();
        #1 rst_n = 1'b1;

        // Randomized traffic with random back-pressure and occasional flush.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
